pl_elastic_reg: RTL and testbench

//  Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/M, M/WB).

---
 rtl/pl_elastic_reg_pkg.sv | 19 +
 rtl/pl_elastic_reg_if.sv | 11 +
 rtl/pl_elastic_reg_ring_ptr.sv | 27 ++
 rtl/pl_elastic_reg.sv | 98 +++++++++
 tb/tb_pl_elastic_reg.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pl_elastic_reg_pkg.sv
// Shared control codes, limits and helpers for the elastic pipeline register.
package pl_elastic_reg_pkg;

  localparam int PL_STATUS_BUS_WIDTH = 2;
  localparam int PL_BUF_MAX_DEPTH    = 8;

  // Any code other than FLUSH or PAUSE means run.
  typedef enum logic [PL_STATUS_BUS_WIDTH-1:0] {
    PL_RUN   = 2'b00,
    PL_FLUSH = 2'b01,
    PL_PAUSE = 2'b10
  } pl_ctrl_e;

  // A single-entry ring still needs a one-bit pointer register.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pl_elastic_reg_if.sv
// Valid/ready/payload bundle for one side of a pipeline-register boundary.
interface pl_elastic_reg_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pl_elastic_reg_ring_ptr.sv
// Modulo-DEPTH ring pointer; wraps from DEPTH-1 back to 0 explicitly.
module pl_ring_ptr
  import pl_elastic_reg_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/pl_elastic_reg.sv
// Elastic pipeline register: DEPTH-entry ring buffer behind valid/ready, with
// FLUSH/PAUSE stage control. State updates on the falling clock edge.
module pl_elastic_reg
  import pl_elastic_reg_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 2,
  parameter bit               READY_PASS = 1'b1,
  parameter logic [WIDTH-1:0] FLUSH_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic [PL_STATUS_BUS_WIDTH-1:0] pl_ctrl,
  pl_elastic_reg_if.slave                in_bus,
  pl_elastic_reg_if.master               out_bus,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  generate
    if (DEPTH < 1 || DEPTH > PL_BUF_MAX_DEPTH || WIDTH < 1 || WIDTH > 256) begin : g_bad_param
      $error("pl_elastic_reg: WIDTH/DEPTH out of range");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_reg;
  logic             flush, pause, active;
  logic             in_ready, out_valid, push, pop;

  // FLUSH outranks PAUSE; holding clr low also blocks both handshakes.
  assign flush  = (pl_ctrl == PL_FLUSH);
  assign pause  = (pl_ctrl == PL_PAUSE);
  assign active = clr & ~flush & ~pause;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign count     = count_reg;
  assign out_valid = active & ~empty;

  generate
    if (READY_PASS) begin : g_pass
      assign in_ready = active & (~full | out_bus.ready);
    end else begin : g_no_pass
      assign in_ready = active & ~full;
    end
  endgenerate

  assign push = in_bus.valid & in_ready;
  assign pop  = out_valid & out_bus.ready;

  assign in_bus.ready  = in_ready;
  assign out_bus.valid = out_valid;
  assign out_bus.data  = empty ? FLUSH_VAL : mem[rd_ptr];

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= FLUSH_VAL;
    end else if (push) begin
      mem[wr_ptr] <= in_bus.data;
    end
  end

  // Occupancy is tracked on its own so full and empty never alias when pointers meet.
  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      count_reg <= '0;
    end else if (flush) begin
      count_reg <= '0;
    end else if (push && !pop) begin
      count_reg <= count_reg + CNT_W'(1);
    end else if (pop && !push) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  pl_ring_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .clr   (clr),
    .clear (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  pl_ring_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .clr   (clr),
    .clear (flush),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

endmodule

// File: tb/tb_pl_elastic_reg.sv
// Bench for pl_elastic_reg: directed scenarios on three configurations plus a
// randomized run against a queue-based reference model.
module tb_pl_elastic_reg;
  import pl_elastic_reg_pkg::*;

  logic clk, clr;
  logic [PL_STATUS_BUS_WIDTH-1:0] ctrl2, ctrl3, ctrl1;
  logic [1:0] cnt2, cnt3;
  logic [0:0] cnt1;
  logic full2, empty2, full3, empty3, full1, empty1;
  int checks = 0;
  int fails  = 0;

  pl_elastic_reg_if #(.WIDTH(32)) a_in(), a_out(), b_in(), b_out(), c_in(), c_out();

  pl_elastic_reg #(.WIDTH(32), .DEPTH(2), .READY_PASS(1'b1)) dut2 (
    .clk(clk), .clr(clr), .pl_ctrl(ctrl2), .in_bus(a_in), .out_bus(a_out),
    .count(cnt2), .full(full2), .empty(empty2));

  pl_elastic_reg #(.WIDTH(32), .DEPTH(3), .READY_PASS(1'b0)) dut3 (
    .clk(clk), .clr(clr), .pl_ctrl(ctrl3), .in_bus(b_in), .out_bus(b_out),
    .count(cnt3), .full(full3), .empty(empty3));

  pl_elastic_reg #(.WIDTH(32), .DEPTH(1), .READY_PASS(1'b1)) dut1 (
    .clk(clk), .clr(clr), .pl_ctrl(ctrl1), .in_bus(c_in), .out_bus(c_out),
    .count(cnt1), .full(full1), .empty(empty1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    @(posedge clk); #1;
    checks++; if (a_out.valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", a_out.valid); end
    checks++; if (cnt2 !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", cnt2); end
    checks++; if (a_out.data !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h want 0", a_out.data); end
    checks++; if (a_in.ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %0b want 0", a_in.ready); end
    checks++; if (empty2 !== 1'b1 || full2 !== 1'b0) begin fails++; $display("FAIL reset_flags: empty %0b full %0b want 1 0", empty2, full2); end
    clr = 1'b1; #1;
    checks++; if (a_in.ready !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %0b want 1", a_in.ready); end
    @(posedge clk); a_in.valid = 1'b0; #1;
    checks++; if (a_out.valid !== 1'b1 || a_out.data !== 32'hDEADBEEF) begin fails++; $display("FAIL first_push: valid %0b data %h want 1 deadbeef", a_out.valid, a_out.data); end
    checks++; if (cnt2 !== 2'd1) begin fails++; $display("FAIL first_push_count: got %0d want 1", cnt2); end
    a_in.valid = 1'b1; a_in.data = 32'h55; #1;
    clr = 1'b0; #1;
    checks++; if (cnt2 !== 2'd0 || a_out.valid !== 1'b0 || a_out.data !== 32'h0) begin fails++; $display("FAIL async_reset: count %0d valid %0b data %h want 0 0 0", cnt2, a_out.valid, a_out.data); end
    a_in.valid = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    checks++; if (empty2 !== 1'b1 || a_out.valid !== 1'b0) begin fails++; $display("FAIL after_async_reset: empty %0b valid %0b want 1 0", empty2, a_out.valid); end
    $display("test_reset done");
  endtask

  task automatic test_streaming;
    a_out.ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      a_in.valid = (k < 4);
      a_in.data  = 32'(k + 1);
      #1;
      if (k < 4) begin
        checks++; if (a_in.ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d]: got %0b want 1", k, a_in.ready); end
      end
      if (k >= 1 && k <= 4) begin
        checks++; if (a_out.valid !== 1'b1 || a_out.data !== 32'(k)) begin fails++; $display("FAIL stream_out[%0d]: valid %0b data %0d want 1 %0d", k, a_out.valid, a_out.data, k); end
      end
      checks++; if (cnt2 !== ((k >= 1 && k <= 4) ? 2'd1 : 2'd0)) begin fails++; $display("FAIL stream_count[%0d]: got %0d", k, cnt2); end
    end
    a_out.ready = 1'b0;
    $display("test_streaming done");
  endtask

  task automatic test_pause;
    @(posedge clk); a_in.valid = 1'b1; a_in.data = 32'hA1; a_out.ready = 1'b0;
    @(posedge clk); a_in.data = 32'hA2;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); ctrl2 = PL_PAUSE; a_in.valid = 1'b1; a_in.data = 32'hFF; a_out.ready = 1'b1; #1;
      checks++; if (a_in.ready !== 1'b0 || a_out.valid !== 1'b0) begin fails++; $display("FAIL pause_hs[%0d]: in_ready %0b out_valid %0b want 0 0", k, a_in.ready, a_out.valid); end
      checks++; if (cnt2 !== 2'd2 || a_out.data !== 32'hA1) begin fails++; $display("FAIL pause_hold[%0d]: count %0d data %h want 2 a1", k, cnt2, a_out.data); end
    end
    @(posedge clk); ctrl2 = PL_RUN; a_in.valid = 1'b0; #1;
    checks++; if (a_out.valid !== 1'b1 || a_out.data !== 32'hA1) begin fails++; $display("FAIL resume_head: valid %0b data %h want 1 a1", a_out.valid, a_out.data); end
    @(posedge clk); #1;
    checks++; if (a_out.data !== 32'hA2 || cnt2 !== 2'd1) begin fails++; $display("FAIL resume_second: data %h count %0d want a2 1", a_out.data, cnt2); end
    @(posedge clk); #1;
    checks++; if (empty2 !== 1'b1) begin fails++; $display("FAIL resume_drain: empty %0b want 1", empty2); end
    a_out.ready = 1'b0;
    $display("test_pause done");
  endtask

  task automatic test_flush;
    @(posedge clk); a_in.valid = 1'b1; a_in.data = 32'hB1; a_out.ready = 1'b0;
    @(posedge clk); a_in.data = 32'hB2;
    @(posedge clk); ctrl2 = PL_FLUSH; a_in.data = 32'hCC; a_out.ready = 1'b1; #1;
    checks++; if (a_in.ready !== 1'b0 || a_out.valid !== 1'b0 || cnt2 !== 2'd2) begin fails++; $display("FAIL flush_cycle: in_ready %0b out_valid %0b count %0d want 0 0 2", a_in.ready, a_out.valid, cnt2); end
    @(posedge clk); ctrl2 = PL_RUN; a_in.data = 32'hE1; a_out.ready = 1'b0; #1;
    checks++; if (cnt2 !== 2'd0 || empty2 !== 1'b1 || a_out.data !== 32'h0 || a_out.valid !== 1'b0) begin fails++; $display("FAIL flush_result: count %0d empty %0b data %h valid %0b want 0 1 0 0", cnt2, empty2, a_out.data, a_out.valid); end
    @(posedge clk); a_in.valid = 1'b0; #1;
    checks++; if (a_out.data !== 32'hE1 || cnt2 !== 2'd1) begin fails++; $display("FAIL post_flush_push: data %h count %0d want e1 1", a_out.data, cnt2); end
    a_out.ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (empty2 !== 1'b1) begin fails++; $display("FAIL post_flush_drain: empty %0b want 1", empty2); end
    a_out.ready = 1'b0;
    $display("test_flush done");
  endtask

  task automatic test_wrap;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); b_in.valid = 1'b1; b_in.data = 32'hA0 + 32'(k); b_out.ready = 1'b0; #1;
      checks++; if (b_in.ready !== 1'b1) begin fails++; $display("FAIL wrap_fill[%0d]: in_ready %0b want 1", k, b_in.ready); end
    end
    @(posedge clk); b_in.data = 32'hEE; b_out.ready = 1'b1; #1;
    checks++; if (full3 !== 1'b1 || b_in.ready !== 1'b0 || b_out.data !== 32'hA0) begin fails++; $display("FAIL wrap_full: full %0b in_ready %0b data %h want 1 0 a0", full3, b_in.ready, b_out.data); end
    @(posedge clk); b_in.data = 32'hA3; b_out.ready = 1'b0; #1;
    checks++; if (cnt3 !== 2'd2 || b_in.ready !== 1'b1) begin fails++; $display("FAIL wrap_push: count %0d in_ready %0b want 2 1", cnt3, b_in.ready); end
    @(posedge clk); b_in.valid = 1'b0; b_out.ready = 1'b1; #1;
    checks++; if (full3 !== 1'b1 || b_out.data !== 32'hA1) begin fails++; $display("FAIL wrap_drain0: full %0b data %h want 1 a1", full3, b_out.data); end
    @(posedge clk); #1;
    checks++; if (b_out.data !== 32'hA2) begin fails++; $display("FAIL wrap_drain1: data %h want a2", b_out.data); end
    @(posedge clk); #1;
    checks++; if (b_out.data !== 32'hA3) begin fails++; $display("FAIL wrap_drain2: data %h want a3", b_out.data); end
    @(posedge clk); #1;
    checks++; if (empty3 !== 1'b1) begin fails++; $display("FAIL wrap_empty: empty %0b want 1", empty3); end
    b_out.ready = 1'b0;
    $display("test_wrap done");
  endtask

  task automatic test_simul_push_pop;
    @(posedge clk); c_in.valid = 1'b1; c_in.data = 32'd5; c_out.ready = 1'b0; #1;
    checks++; if (c_in.ready !== 1'b1) begin fails++; $display("FAIL d1_first: in_ready %0b want 1", c_in.ready); end
    @(posedge clk); c_in.data = 32'd7; #1;
    checks++; if (full1 !== 1'b1 || c_in.ready !== 1'b0) begin fails++; $display("FAIL d1_full_blocked: full %0b in_ready %0b want 1 0", full1, c_in.ready); end
    c_out.ready = 1'b1; #1;
    checks++; if (c_in.ready !== 1'b1 || c_out.data !== 32'd5) begin fails++; $display("FAIL d1_pass: in_ready %0b data %0d want 1 5", c_in.ready, c_out.data); end
    @(posedge clk); c_in.valid = 1'b0; c_out.ready = 1'b0; #1;
    checks++; if (cnt1 !== 1'b1 || c_out.data !== 32'd7 || full1 !== 1'b1) begin fails++; $display("FAIL d1_swap: count %0d data %0d full %0b want 1 7 1", cnt1, c_out.data, full1); end
    c_out.ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (empty1 !== 1'b1) begin fails++; $display("FAIL d1_drain: empty %0b want 1", empty1); end
    c_out.ready = 1'b0;
    $display("test_simul_push_pop done");
  endtask

  function automatic logic [PL_STATUS_BUS_WIDTH-1:0] rand_ctrl();
    int r = $urandom_range(0, 19);
    if (r == 0) return PL_FLUSH;
    if (r <= 2) return PL_PAUSE;
    if (r == 3) return 2'b11;
    return PL_RUN;
  endfunction

  task automatic test_random;
    logic [31:0] q2[$];
    logic [31:0] q3[$];
    logic run, e_v, e_r;
    logic [31:0] e_d;
    // Start both models from a known empty state.
    @(posedge clk); ctrl2 = PL_FLUSH; ctrl3 = PL_FLUSH;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      ctrl2 = rand_ctrl(); ctrl3 = rand_ctrl();
      a_in.valid = ($urandom_range(0, 3) != 0); a_in.data = $urandom; a_out.ready = ($urandom_range(0, 1) != 0);
      b_in.valid = ($urandom_range(0, 3) != 0); b_in.data = $urandom; b_out.ready = ($urandom_range(0, 1) != 0);
      #1;
      run = (ctrl2 != PL_FLUSH) && (ctrl2 != PL_PAUSE);
      e_v = run && (q2.size() != 0);
      e_r = run && (q2.size() < 2 || (a_out.ready && q2.size() == 2));
      e_d = (q2.size() != 0) ? q2[0] : 32'h0;
      checks++; if (a_out.valid !== e_v || a_in.ready !== e_r) begin fails++; $display("FAIL rnd2_hs[%0d]: valid %0b ready %0b want %0b %0b", n, a_out.valid, a_in.ready, e_v, e_r); end
      checks++; if (a_out.data !== e_d) begin fails++; $display("FAIL rnd2_data[%0d]: got %h want %h", n, a_out.data, e_d); end
      checks++; if (int'(cnt2) !== q2.size() || empty2 !== (q2.size() == 0) || full2 !== (q2.size() == 2)) begin fails++; $display("FAIL rnd2_count[%0d]: count %0d empty %0b full %0b want %0d", n, cnt2, empty2, full2, q2.size()); end
      checks++; if (cnt2 > 2'd2) begin fails++; $display("FAIL rnd2_range[%0d]: count %0d exceeds 2", n, cnt2); end
      if (ctrl2 == PL_FLUSH) q2.delete();
      else begin
        if (e_v && a_out.ready) void'(q2.pop_front());
        if (e_r && a_in.valid) q2.push_back(a_in.data);
      end
      run = (ctrl3 != PL_FLUSH) && (ctrl3 != PL_PAUSE);
      e_v = run && (q3.size() != 0);
      e_r = run && (q3.size() < 3);
      e_d = (q3.size() != 0) ? q3[0] : 32'h0;
      checks++; if (b_out.valid !== e_v || b_in.ready !== e_r) begin fails++; $display("FAIL rnd3_hs[%0d]: valid %0b ready %0b want %0b %0b", n, b_out.valid, b_in.ready, e_v, e_r); end
      checks++; if (b_out.data !== e_d) begin fails++; $display("FAIL rnd3_data[%0d]: got %h want %h", n, b_out.data, e_d); end
      checks++; if (int'(cnt3) !== q3.size() || empty3 !== (q3.size() == 0) || full3 !== (q3.size() == 3)) begin fails++; $display("FAIL rnd3_count[%0d]: count %0d empty %0b full %0b want %0d", n, cnt3, empty3, full3, q3.size()); end
      checks++; if (cnt3 > 2'd3) begin fails++; $display("FAIL rnd3_range[%0d]: count %0d exceeds 3", n, cnt3); end
      if (ctrl3 == PL_FLUSH) q3.delete();
      else begin
        if (e_v && b_out.ready) void'(q3.pop_front());
        if (e_r && b_in.valid) q3.push_back(b_in.data);
      end
    end
    ctrl2 = PL_RUN; ctrl3 = PL_RUN;
    a_in.valid = 1'b0; a_out.ready = 1'b0; b_in.valid = 1'b0; b_out.ready = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    clr = 1'b0;
    ctrl2 = PL_RUN; ctrl3 = PL_RUN; ctrl1 = PL_RUN;
    a_in.valid = 1'b1; a_in.data = 32'hDEADBEEF; a_out.ready = 1'b0;
    b_in.valid = 1'b0; b_in.data = 32'h0; b_out.ready = 1'b0;
    c_in.valid = 1'b0; c_in.data = 32'h0; c_out.ready = 1'b0;
    test_reset();
    test_streaming();
    test_pause();
    test_flush();
    test_wrap();
    test_simul_push_pop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
